// File: rtl/block_pkg.sv
// Shared types and sizes for the block window loader.
package block_pkg;

    localparam int unsigned NUM_SLOTS = 12;
    localparam int unsigned TIME_W    = 18;
    localparam int unsigned COORD_W   = 12;
    localparam int unsigned ID_W      = 8;
    localparam int unsigned DIR_W     = 3;

    // Field order matches the beatmap ROM word, MSB first.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [TIME_W-1:0]  hit_time;
        logic               color;
        logic [DIR_W-1:0]   direction;
        logic [ID_W-1:0]    id;
    } block_t;

    localparam int unsigned BLOCK_W = $bits(block_t);

    typedef enum logic [2:0] {
        IDLE,
        EVICT,
        FETCH,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/block_window_loader_if.sv
// Beatmap ROM read bus: the loader drives the address, the ROM returns the word.
interface block_window_loader_if #(
    parameter int unsigned ADDR_W = 10
) ();

    logic [ADDR_W-1:0]             rom_addr_out;
    logic [block_pkg::BLOCK_W-1:0] rom_data_in;

    modport master (output rom_addr_out, input rom_data_in);
    modport slave  (input rom_addr_out, output rom_data_in);

endinterface

// File: rtl/block_slot_window.sv
// Time-ordered slot array: shift-down eviction, append at fill level, clear on reset.
module block_slot_window #(
    parameter int unsigned NUM_SLOTS = block_pkg::NUM_SLOTS,
    parameter int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 shift,
    input  logic                                 append,
    input  block_pkg::block_t                    data,
    output block_pkg::block_t [NUM_SLOTS-1:0]    slots,
    output logic [CNT_W-1:0]                     count
);
    import block_pkg::*;

    // Shift and append are never requested in the same cycle by the loader.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            slots <= '0;
            count <= '0;
        end else if (shift) begin
            for (int unsigned i = 0; i + 1 < NUM_SLOTS; i++) begin
                slots[i] <= slots[i+1];
            end
            slots[NUM_SLOTS-1] <= '0;
            count <= count - 1'b1;
        end else if (append) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (count == CNT_W'(i)) begin
                    slots[i] <= data;
                end
            end
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/block_window_loader.sv
// Per-frame window scheduler: evicts past blocks, refills from the beatmap ROM,
// then publishes a snapshot of all slots in one cycle.
// Optional statistics outputs are enabled by defining BLOCK_WINDOW_STATS_EN.
module block_window_loader #(
    parameter int unsigned NUM_SLOTS   = block_pkg::NUM_SLOTS,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          frame_start_in,
    input  logic [block_pkg::TIME_W-1:0]                  curr_time_in,
    input  logic [ADDR_W-1:0]                             num_blocks_in,
    block_window_loader_if.master                         rom,
    output logic [block_pkg::TIME_W-1:0]                  curr_time_out,
    output logic [NUM_SLOTS-1:0][block_pkg::COORD_W-1:0]  block_x_out,
    output logic [NUM_SLOTS-1:0][block_pkg::COORD_W-1:0]  block_y_out,
    output logic [NUM_SLOTS-1:0][block_pkg::TIME_W-1:0]   block_time_out,
    output logic [NUM_SLOTS-1:0]                          block_color_out,
    output logic [NUM_SLOTS-1:0][block_pkg::DIR_W-1:0]    block_direction_out,
    output logic [NUM_SLOTS-1:0][block_pkg::ID_W-1:0]     block_ID_out,
    output logic                                          snapshot_valid_out,
    output logic                                          busy_out,
    output logic                                          song_done_out
`ifdef BLOCK_WINDOW_STATS_EN
    ,
    output logic [15:0]                                   missed_frames_out,
    output logic [15:0]                                   evicted_count_out
`endif
);
    import block_pkg::*;

    localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);
    localparam int unsigned WAIT_W = $clog2(ROM_LATENCY + 1);

    state_t                   state;
    logic [TIME_W-1:0]        cur_time;
    logic [ADDR_W-1:0]        next_addr;
    logic [WAIT_W-1:0]        wait_cnt;
    block_t                   fetched;
    block_t [NUM_SLOTS-1:0]   slots;
    logic [CNT_W-1:0]         count;
    logic                     evict_now;
    logic                     wait_done;
    logic                     keep_fetch;
    logic                     drop_fetch;
    logic                     fetch_go;

    // The address is taken straight from next_addr, so the ROM access starts in
    // FETCH and the word is valid after ROM_LATENCY WAIT cycles.
    assign rom.rom_addr_out = next_addr;
    assign fetched          = block_t'(rom.rom_data_in);

    block_slot_window #(
        .NUM_SLOTS (NUM_SLOTS),
        .CNT_W     (CNT_W)
    ) u_window (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .shift  (evict_now),
        .append (keep_fetch),
        .data   (fetched),
        .slots  (slots),
        .count  (count)
    );

    // Window operations decoded from the current state.
    always_comb begin
        evict_now  = (state == EVICT) && (count != '0) && (slots[0].hit_time < cur_time);
        wait_done  = (state == WAIT) && (wait_cnt == WAIT_W'(ROM_LATENCY - 1));
        keep_fetch = wait_done && (fetched.hit_time >= cur_time);
        drop_fetch = wait_done && (fetched.hit_time < cur_time);
        fetch_go   = (count < CNT_W'(NUM_SLOTS)) && (next_addr < num_blocks_in);
    end

    // Frame sequencer with registered status and snapshot outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state               <= IDLE;
            cur_time            <= '0;
            next_addr           <= '0;
            wait_cnt            <= '0;
            curr_time_out       <= '0;
            block_x_out         <= '0;
            block_y_out         <= '0;
            block_time_out      <= '0;
            block_color_out     <= '0;
            block_direction_out <= '0;
            block_ID_out        <= '0;
            snapshot_valid_out  <= 1'b0;
            busy_out            <= 1'b0;
            song_done_out       <= 1'b0;
        end else begin
            snapshot_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start_in) begin
                        cur_time <= curr_time_in;
                        busy_out <= 1'b1;
                        state    <= EVICT;
                    end
                end
                EVICT: begin
                    if (!evict_now) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_go) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        state <= DONE;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        if (next_addr < num_blocks_in) begin
                            next_addr <= next_addr + 1'b1;
                        end
                        state <= FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    curr_time_out <= cur_time;
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        block_x_out[i]         <= slots[i].x;
                        block_y_out[i]         <= slots[i].y;
                        block_time_out[i]      <= slots[i].hit_time;
                        block_color_out[i]     <= slots[i].color;
                        block_direction_out[i] <= slots[i].direction;
                        block_ID_out[i]        <= slots[i].id;
                    end
                    snapshot_valid_out <= 1'b1;
                    busy_out           <= 1'b0;
                    if ((next_addr == num_blocks_in) && (count == '0)) begin
                        song_done_out <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLOCK_WINDOW_STATS_EN
    // Saturating counters for ignored frames and dropped blocks.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            missed_frames_out <= '0;
            evicted_count_out <= '0;
        end else begin
            if (frame_start_in && (state != IDLE) && (missed_frames_out != '1)) begin
                missed_frames_out <= missed_frames_out + 1'b1;
            end
            if ((evict_now || drop_fetch) && (evicted_count_out != '1)) begin
                evicted_count_out <= evicted_count_out + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_window_loader.sv
// Randomised scoreboard bench for block_window_loader with a queue-based window model.
module tb_block_window_loader;
    import block_pkg::*;

    localparam int unsigned ADDR_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                 rst_n;
    logic                                 frame_start;
    logic [TIME_W-1:0]                    curr_time;
    logic [ADDR_W-1:0]                    num_blocks;
    logic [TIME_W-1:0]                    curr_time_out;
    logic [NUM_SLOTS-1:0][COORD_W-1:0]    block_x_out;
    logic [NUM_SLOTS-1:0][COORD_W-1:0]    block_y_out;
    logic [NUM_SLOTS-1:0][TIME_W-1:0]     block_time_out;
    logic [NUM_SLOTS-1:0]                 block_color_out;
    logic [NUM_SLOTS-1:0][DIR_W-1:0]      block_direction_out;
    logic [NUM_SLOTS-1:0][ID_W-1:0]       block_ID_out;
    logic                                 snapshot_valid_out;
    logic                                 busy_out;
    logic                                 song_done_out;
`ifdef BLOCK_WINDOW_STATS_EN
    logic [15:0]                          missed_frames_out;
    logic [15:0]                          evicted_count_out;
`endif

    block_window_loader_if #(.ADDR_W(ADDR_W)) rom_bus ();

    block_window_loader #(
        .NUM_SLOTS   (NUM_SLOTS),
        .ADDR_W      (ADDR_W),
        .ROM_LATENCY (2)
    ) dut (
        .clk_in              (clk),
        .rst_in              (rst_n),
        .frame_start_in      (frame_start),
        .curr_time_in        (curr_time),
        .num_blocks_in       (num_blocks),
        .rom                 (rom_bus),
        .curr_time_out       (curr_time_out),
        .block_x_out         (block_x_out),
        .block_y_out         (block_y_out),
        .block_time_out      (block_time_out),
        .block_color_out     (block_color_out),
        .block_direction_out (block_direction_out),
        .block_ID_out        (block_ID_out),
        .snapshot_valid_out  (snapshot_valid_out),
        .busy_out            (busy_out),
        .song_done_out       (song_done_out)
`ifdef BLOCK_WINDOW_STATS_EN
        ,
        .missed_frames_out   (missed_frames_out),
        .evicted_count_out   (evicted_count_out)
`endif
    );

    // Beatmap ROM with two register stages of read latency.
    logic [BLOCK_W-1:0] rom_mem [1024];
    logic [BLOCK_W-1:0] stage1, stage2;
    always @(posedge clk) begin
        stage1 <= rom_mem[rom_bus.rom_addr_out];
        stage2 <= stage1;
    end
    assign rom_bus.rom_data_in = stage2;

    typedef struct {
        logic [TIME_W-1:0] t;
        block_t            s [NUM_SLOTS];
        bit                done;
    } snap_t;

    int     total = 0;
    int     bad   = 0;
    int     snaps = 0;
    snap_t  exp_q [$];
    block_t win_q [$];
    int     m_next;
    bit     m_done;
    int     exp_missed;
    int     exp_evicted;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        win_q.delete();
        exp_q.delete();
        m_next      = 0;
        m_done      = 1'b0;
        exp_missed  = 0;
        exp_evicted = 0;
    endfunction

    // Window rules: drop past blocks from the front, then fill from the ROM in order.
    function automatic void model_frame(input logic [TIME_W-1:0] t);
        snap_t  e;
        block_t b;
        while (win_q.size() > 0 && win_q[0].hit_time < t) begin
            void'(win_q.pop_front());
            exp_evicted++;
        end
        while (win_q.size() < NUM_SLOTS && m_next < int'(num_blocks)) begin
            b = rom_mem[m_next];
            m_next++;
            if (b.hit_time < t) exp_evicted++;
            else win_q.push_back(b);
        end
        if (m_next == int'(num_blocks) && win_q.size() == 0) m_done = 1'b1;
        e.t    = t;
        e.done = m_done;
        for (int i = 0; i < NUM_SLOTS; i++) e.s[i] = (i < win_q.size()) ? win_q[i] : '0;
        exp_q.push_back(e);
    endfunction

    // Monitor: every snapshot pulse is matched against the oldest expectation.
    initial begin
        snap_t  e;
        block_t a;
        forever begin
            @(posedge clk);
            #1;
            if (snapshot_valid_out === 1'b1) begin
                snaps++;
                if (exp_q.size() == 0) begin
                    check("unexpected_snapshot_qdepth", 64'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("snap_curr_time", curr_time_out, e.t);
                    check("snap_song_done", song_done_out, e.done);
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        a = '{x: block_x_out[i], y: block_y_out[i], hit_time: block_time_out[i],
                              color: block_color_out[i], direction: block_direction_out[i],
                              id: block_ID_out[i]};
                        check($sformatf("slot%0d", i), a, e.s[i]);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, snapshot_valid_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_song_done"}, song_done_out, 0);
        check({tag, "_rom_addr"}, rom_bus.rom_addr_out, 0);
        check({tag, "_curr_time"}, curr_time_out, 0);
        check({tag, "_slots"}, |{block_x_out, block_y_out, block_time_out, block_color_out,
                                 block_direction_out, block_ID_out}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic load_rom(input int nb, input bit directed);
        logic [TIME_W-1:0] t;
        block_t b;
        t = TIME_W'($urandom_range(0, 150));
        for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
        for (int i = 0; i < nb; i++) begin
            b = block_t'({$urandom, $urandom});
            if (directed) b.hit_time = TIME_W'(100 * (i + 1));
            else begin
                t = t + TIME_W'($urandom_range(0, 300));
                b.hit_time = t;
            end
            rom_mem[i] = b;
        end
        num_blocks = ADDR_W'(nb);
    endtask

    // Issue one frame; extra_at>0 re-pulses frame_start extra_at cycles after the accept edge.
    task automatic frame(input logic [TIME_W-1:0] t, input int extra_at);
        int start;
        bit got;
        @(negedge clk);
        frame_start = 1'b1;
        curr_time   = t;
        @(negedge clk);
        frame_start = 1'b0;
        curr_time   = TIME_W'($urandom);
        model_frame(t);
        check("busy_after_accept", busy_out, 1);
        start = snaps;
        if (extra_at > 0) begin
            repeat (extra_at - 1) @(negedge clk);
            frame_start = 1'b1;
            curr_time   = TIME_W'($urandom);
            @(negedge clk);
            frame_start = 1'b0;
            exp_missed++;
        end
        got = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            got = (snaps != start);
        end
        check("snapshot_arrived", got, 1);
        check("busy_released", busy_out, 0);
`ifdef BLOCK_WINDOW_STATS_EN
        check("missed_frames", missed_frames_out, exp_missed);
        check("evicted_count", evicted_count_out, exp_evicted);
`endif
        repeat (2) @(negedge clk);
    endtask

    // Reset asserted while the first ROM read of a frame is outstanding.
    task automatic abort_test();
        @(negedge clk);
        frame_start = 1'b1;
        curr_time   = '0;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("abort");
        model_reset();
        repeat (60) @(negedge clk);
        check("abort_no_snapshot_qdepth", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fsnaps;
        logic [TIME_W-1:0] ft;
        rst_n = 1'b0;
        frame_start = 1'b0;
        curr_time = '0;
        num_blocks = '0;
        model_reset();

        load_rom(20, 1'b1);
        do_reset();
        frame(18'd0, 5);
        check("t0_first_time", block_time_out[0], 100);
        check("t0_last_time", block_time_out[11], 1200);
        frame(18'd350, 0);
        check("t350_first_time", block_time_out[0], 400);
        check("t350_last_time", block_time_out[11], 1500);
        frame(18'd400, 0);
        check("t400_kept", block_time_out[0], 400);
        frame(18'd401, 0);
        check("t401_evicted", block_time_out[0], 500);
        frame(18'd450, 0);
        frame(18'd5000, 0);
        check("t5000_done", song_done_out, 1);
        check("t5000_empty", |block_time_out, 0);
        frame(18'd6000, 0);
        check("done_sticky", song_done_out, 1);

        do_reset();
        abort_test();
        frame(18'd0, 5);
        check("after_abort_first", block_time_out[0], 100);

        for (int r = 0; r < 3; r++) begin
            load_rom($urandom_range(20, 60), 1'b0);
            do_reset();
            ft = '0;
            for (int k = 0; k < 14; k++) begin
                ft = ft + TIME_W'($urandom_range(0, 900));
                frame(ft, ($urandom_range(0, 3) == 0) ? 2 : 0);
            end
            frame(18'h3FFFF, 0);
            check("random_drain_done", song_done_out, 1);
        end

        fsnaps = snaps;
        repeat (10) @(negedge clk);
        check("no_stray_snapshots", 64'(snaps - fsnaps), 0);
        check("queue_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_window_loader.md
Name: block_window_loader

Overview:
- Per-frame scheduler that keeps the 12 nearest upcoming blocks of the song in a time-ordered window.
- Streams entries from the beatmap ROM and evicts blocks whose time has passed.
- Presents a coherent snapshot to block_positions once per frame.
- Sits between the beatmap ROM and block_positions, and is triggered by the frame/time generator.

Parameters:
- NUM_SLOTS, 12, window depth; must match block_positions.
- ADDR_W, 10, beatmap ROM address width.
- ROM_LATENCY, 2, cycles from rom_addr_out change to valid rom_data_in.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low; all state cleared when rst_in==0 at a clk_in edge
- frame_start_in  input  1  one-cycle pulse; starts an update using curr_time_in
- curr_time_in  input  18  song time sampled on frame_start_in
- num_blocks_in  input  ADDR_W  number of valid ROM entries
- rom_addr_out  output  ADDR_W  beatmap ROM read address
- rom_data_in  input  54  {x[11:0], y[11:0], time[17:0], color, direction[2:0], ID[7:0]}
- curr_time_out  output  18  time the snapshot was built for
- block_x_out, block_y_out  output  12x12  slot positions
- block_time_out  output  12x18  slot times
- block_color_out  output  12  slot colors
- block_direction_out  output  12x3  slot directions
- block_ID_out  output  12x8  slot IDs
- snapshot_valid_out  output  1  one-cycle pulse when snapshot outputs update
- busy_out  output  1  high from the frame_start_in accept cycle through DONE
- song_done_out  output  1  sticky; all entries fetched and window empty

Behaviour:
- Reset:
  - All outputs 0; window count 0; next_addr 0; state IDLE.
  - Empty slots carry time 0, so block_positions treats them as invisible.
- IDLE:
  - On frame_start_in, latch curr_time_in, assert busy_out, go to EVICT.
  - frame_start_in while busy is ignored; no queuing.
- EVICT:
  - Each cycle, if count>0 and slot[0].time < latched time (strict), shift slots down by one, zero the top slot, decrement count.
  - Otherwise go to FETCH.
  - A block with time == curr_time is kept.
  - Maximum 12 cycles.
- FETCH:
  - If count<NUM_SLOTS and next_addr<num_blocks_in, drive rom_addr_out=next_addr and go to WAIT.
  - Otherwise go to DONE.
- WAIT:
  - Count ROM_LATENCY cycles, then write rom_data_in into slot[count], count++, next_addr++, return to FETCH.
  - rom_addr_out holds stable throughout WAIT.
  - A fetched entry whose time < latched time is discarded; next_addr still increments and count does not.
- DONE:
  - Copy window registers to all block_*_out and curr_time_out in one cycle.
  - Pulse snapshot_valid_out; deassert busy_out next cycle; go to IDLE.
  - Outputs hold between snapshots and never show partial updates.
- Worst-case latency: 1 + 12 + 12*(ROM_LATENCY+1) + 1 cycles = 50 at defaults; must fit well inside one frame.
- song_done_out:
  - Set in DONE when next_addr==num_blocks_in and count==0.
  - Cleared only by reset.
- Reset mid-operation: abort immediately; no snapshot pulse; outputs return to 0.
- Widths:
  - Time compare is unsigned 18-bit; no wrap handling, since the song time is monotonic.
  - next_addr saturates at num_blocks_in.

Optional Feature:
- Macro BLOCK_WINDOW_STATS_EN.
- Defined: adds outputs missed_frames_out[15:0] and evicted_count_out[15:0].
  - missed_frames_out counts frame_start_in pulses ignored while busy.
  - evicted_count_out counts EVICT shifts plus discarded late fetches.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package block_pkg holds:
  - block_t packed struct (x, y, time, color, direction, ID; 54 bits, same order as rom_data_in)
  - NUM_SLOTS=12, TIME_W=18, COORD_W=12, ID_W=8
  - state enum {IDLE, EVICT, FETCH, WAIT, DONE}
- One sub-module, block_slot_window, holds the slot array with shift-down, append-at-count and clear operations. The FSM stays in block_window_loader.

Test Plan:
- ROM times 100,200,...,2000, num_blocks=20; reset release, frame_start with time 0 -> after 50 cycles snapshot_valid pulse; slots hold times 100..1200 and curr_time_out=0.
- Then frame_start with time 350 -> slots 100,200,300 evicted; slots hold 400..1500; snapshot within 1+3+3*3+1 cycles.
- Entry time == curr_time (frame at 400) -> slot[0].time stays 400; at time 401 it is evicted.
- frame_start pulsed again 5 cycles after accept -> ignored, exactly one snapshot_valid; with BLOCK_WINDOW_STATS_EN, missed_frames_out=1.
- Frame at time 5000 -> all 20 consumed, window empty, all slot times 0, song_done_out=1 and stays 1 on later frames.
- rst_in driven low during WAIT -> next cycle all outputs 0, state IDLE; the next frame fetches from address 0.
